mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width; legal values are 32 and 64.
REQ-002 SHALL have parameter BE_W, default WIDTH/8, byte-enable width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  the MEM-stage instruction is valid.
REQ-006 SHALL have port req_read / req_write  in  1 each  load or store from the control word.
REQ-007 SHALL have port funct3  in  3  access size and sign.
REQ-008 SHALL have port addr  in  WIDTH  effective address (ALU result).
REQ-009 SHALL have port rs2_data / fwd_data  in  WIDTH each  store data and WB forwarded value.
REQ-010 SHALL have port fwd_sel  in  1  0 selects rs2_data, 1 selects fwd_data.
REQ-011 SHALL have port flush  in  1  kill the current instruction.
REQ-012 SHALL have port dmem_resp / dmem_rdata  in  1 / WIDTH  memory response and read data.
REQ-013 SHALL have port dmem_read / dmem_write  out  1 each  memory request strobes.
REQ-014 SHALL have port dmem_address  out  WIDTH  address aligned to BE_W bytes.
REQ-015 SHALL have port dmem_wdata / dmem_byte_en  out  WIDTH / BE_W  lane-placed write data and byte mask.
REQ-016 SHALL have port stall  out  1  freeze the upstream pipeline.
REQ-017 SHALL have port done / load_data  out  1 / WIDTH  access complete; extended load result.
REQ-018 SHALL have port misaligned  out  1  one-cycle alignment-fault pulse.

Function
REQ-019 FSM states SHALL be IDLE, BUSY and DONE.
REQ-020 In IDLE, req_valid & (req_read|req_write) & ~flush & aligned SHALL accept the request: register address, wdata, byte_en, funct3 and direction; next state BUSY; stall=1 combinationally in the accept cycle.
REQ-021 In BUSY, dmem_read or dmem_write SHALL be held asserted with stable address/data/mask until the cycle dmem_resp=1.
REQ-022 In BUSY, stall SHALL be 1, including the dmem_resp cycle.
REQ-023 In BUSY, dmem_resp SHALL register load_data and move to DONE.
REQ-024 DONE SHALL last exactly one cycle: done=1, stall=0, no new acceptance, then IDLE.
REQ-025 Minimum latency SHALL be: accept at T, request at T+1, resp at T+1, done at T+2.
REQ-026 Alignment SHALL be: byte always aligned; half requires addr[0]=0; word requires addr[1:0]=0; doubleword (funct3=011, WIDTH=64 only) requires addr[2:0]=0.
REQ-027 A misaligned request in IDLE SHALL issue no memory access, pulse misaligned for one cycle, keep stall=0 and stay in IDLE.
REQ-028 dmem_byte_en SHALL be the base mask (1, 3, F, FF by size) shifted left by offset = addr[log2(BE_W)-1:0].
REQ-029 dmem_address SHALL be addr with the low log2(BE_W) bits zeroed.
REQ-030 dmem_wdata SHALL be the selected store source with its low byte/half/word replicated across all lanes.
REQ-031 load_data SHALL be dmem_rdata shifted right by offset*8, then sign- or zero-extended per funct3 (lb, lh, lw sign-extend; lbu, lhu, lwu zero-extend).
REQ-032 Write accesses SHALL leave load_data unchanged.
REQ-033 flush in IDLE SHALL block acceptance.
REQ-034 flush in BUSY SHALL NOT abort the bus; it SHALL set a kill flag that suppresses done and the load_data update in DONE.
REQ-035 An invalid funct3 SHALL be treated as a word access.
REQ-036 Address wrap SHALL be ignored; addr is used modulo 2^WIDTH.

Reset
REQ-037 rst SHALL force IDLE and clear dmem_read, dmem_write, stall, done, misaligned, load_data, dmem_byte_en, the kill flag and all captured registers to 0, effective the next edge.
REQ-038 rst during BUSY SHALL drop the request strobes the following cycle.
REQ-039 A dmem_resp arriving after reset SHALL be ignored.

Structure
REQ-040 The state enum mem_unit_state_t and the load/store funct3 enums SHALL live in rv32i_types.
REQ-041 Load extraction and extension SHALL be a combinational sub-module, mem_load_align, parametrised by WIDTH.
REQ-042 The forwarding mux SHALL use the forwardingmux2 select type.

Verification
REQ-043 sw, addr=0x104, data=0xDEADBEEF, resp at T+3 -> address 0x104, mask 0xF, write held 3 cycles, stall T..T+3, done at T+4.
REQ-044 lb, addr=0x203, rdata=0x80FF_FF12 -> mask 0x8, load_data 0xFFFFFF80; with lbu -> 0x00000080.
REQ-045 sh at addr=0x101 -> misaligned one-cycle pulse, no dmem_write, stall 0.
REQ-046 lw at 0x10, flush at T+1, resp at T+2 -> read completes, done 0, load_data unchanged.
REQ-047 rst in BUSY, then dmem_resp -> IDLE, strobes 0, response ignored.
REQ-048 WIDTH=64, ld at 0x8, rdata=0x0123456789ABCDEF -> mask 0xFF, load_data equals rdata.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the memory stage: FSM states, load/store funct3 codes,
// forwarding select and the access-size decode used by store and load paths.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_unit_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010,
    SD = 3'b011
  } store_funct3_t;

  typedef enum logic {
    FWD_RS2 = 1'b0,
    FWD_WB  = 1'b1
  } forwardingmux2_sel_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } access_size_t;

  // Anything not a recognised size code for the direction falls back to word.
  function automatic access_size_t decode_size(input logic [2:0] f3,
                                               input logic       is_load,
                                               input logic       dword_ok);
    access_size_t sz;
    sz = SZ_WORD;
    case (f3)
      LB:      sz = SZ_BYTE;
      LH:      sz = SZ_HALF;
      LW:      sz = SZ_WORD;
      LD:      sz = dword_ok ? SZ_DWORD : SZ_WORD;
      LBU:     sz = is_load ? SZ_BYTE : SZ_WORD;
      LHU:     sz = is_load ? SZ_HALF : SZ_WORD;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Moves the addressed bytes of a bus read down to bit 0 and sign- or
// zero-extends them according to the load's funct3.
module mem_load_align
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]           rdata,
  input  logic [$clog2(WIDTH/8)-1:0] offset,
  input  logic [2:0]                 funct3,
  output logic [WIDTH-1:0]           data
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] keep_mask;
  logic             sign_bit;
  access_size_t     size;

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    size      = decode_size(funct3, 1'b1, WIDTH == 64);
    keep_mask = '1;
    sign_bit  = shifted[WIDTH-1];
    case (size)
      SZ_BYTE: begin keep_mask = WIDTH'(8'hFF);         sign_bit = shifted[7];  end
      SZ_HALF: begin keep_mask = WIDTH'(16'hFFFF);      sign_bit = shifted[15]; end
      SZ_WORD: begin keep_mask = WIDTH'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin keep_mask = '1;                    sign_bit = shifted[WIDTH-1]; end
    endcase
    // funct3[2] marks the unsigned load variants
    data = (shifted & keep_mask) | ((~funct3[2] & sign_bit) ? ~keep_mask : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: checks alignment, places store data on byte
// lanes, holds one bus request until the response and stalls the pipeline.
module mem_access_unit
  import rv32i_types::*;
#(
  parameter int WIDTH = 32,
  parameter int BE_W  = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        funct3,
  input  logic [WIDTH-1:0]  addr,
  input  logic [WIDTH-1:0]  rs2_data,
  input  logic [WIDTH-1:0]  fwd_data,
  input  logic              fwd_sel,
  input  logic              flush,
  input  logic              dmem_resp,
  input  logic [WIDTH-1:0]  dmem_rdata,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [WIDTH-1:0]  dmem_address,
  output logic [WIDTH-1:0]  dmem_wdata,
  output logic [BE_W-1:0]   dmem_byte_en,
  output logic              stall,
  output logic              done,
  output logic [WIDTH-1:0]  load_data,
  output logic              misaligned
);

  localparam int OFF_W = $clog2(BE_W);

  mem_unit_state_t   state_reg, state_next;
  logic              kill_reg, kill_next;
  logic [WIDTH-1:0]  addr_reg;
  logic [WIDTH-1:0]  wdata_reg;
  logic [BE_W-1:0]   byte_en_reg;
  logic [2:0]        funct3_reg;
  logic [OFF_W-1:0]  offset_reg;
  logic              is_read_reg;
  logic [WIDTH-1:0]  load_data_reg;
  logic              misaligned_reg;

  logic [OFF_W-1:0]  req_off;
  access_size_t      req_size;
  logic              req_rw;
  logic              aligned;
  logic              accept;
  logic              fault;
  logic [7:0]        base_mask;
  logic [15:0]       be_wide;
  logic [BE_W-1:0]   byte_en_next;
  logic [WIDTH-1:0]  store_src;
  logic [WIDTH-1:0]  wdata_next;
  logic [WIDTH-1:0]  aligned_load;

  // Reads win if the control word ever asserts both strobes.
  always_comb begin
    req_off  = addr[OFF_W-1:0];
    req_size = decode_size(funct3, req_read, WIDTH == 64);
    req_rw   = req_read | req_write;
    case (req_size)
      SZ_BYTE: begin aligned = 1'b1;              base_mask = 8'h01; end
      SZ_HALF: begin aligned = ~addr[0];          base_mask = 8'h03; end
      SZ_WORD: begin aligned = addr[1:0] == 2'b0; base_mask = 8'h0F; end
      default: begin aligned = addr[2:0] == 3'b0; base_mask = 8'hFF; end
    endcase
    accept       = (state_reg == IDLE) & req_valid & req_rw & ~flush & aligned;
    fault        = (state_reg == IDLE) & req_valid & req_rw & ~flush & ~aligned;
    be_wide      = 16'(base_mask) << req_off;
    byte_en_next = be_wide[BE_W-1:0];
    store_src    = (forwardingmux2_sel_t'(fwd_sel) == FWD_WB) ? fwd_data : rs2_data;
    case (req_size)
      SZ_BYTE: wdata_next = {BE_W{store_src[7:0]}};
      SZ_HALF: wdata_next = {(BE_W/2){store_src[15:0]}};
      SZ_WORD: wdata_next = {(BE_W/4){store_src[31:0]}};
      default: wdata_next = store_src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      kill_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      kill_reg  <= kill_next;
    end
  end

  // A flush during the bus phase lets the access finish but hides its result.
  always_comb begin
    state_next = state_reg;
    kill_next  = kill_reg;
    stall      = 1'b0;
    done       = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    case (state_reg)
      IDLE: begin
        kill_next = 1'b0;
        if (accept) begin
          state_next = BUSY;
          stall      = 1'b1;
        end
      end
      BUSY: begin
        stall      = 1'b1;
        dmem_read  = is_read_reg;
        dmem_write = ~is_read_reg;
        if (flush) kill_next = 1'b1;
        if (dmem_resp) state_next = DONE;
      end
      DONE: begin
        done       = ~kill_reg;
        kill_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mem_load_align #(.WIDTH(WIDTH)) u_load_align (
    .rdata  (dmem_rdata),
    .offset (offset_reg),
    .funct3 (funct3_reg),
    .data   (aligned_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg       <= '0;
      wdata_reg      <= '0;
      byte_en_reg    <= '0;
      funct3_reg     <= '0;
      offset_reg     <= '0;
      is_read_reg    <= 1'b0;
      load_data_reg  <= '0;
      misaligned_reg <= 1'b0;
    end else begin
      misaligned_reg <= fault;
      if (accept) begin
        addr_reg    <= {addr[WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        wdata_reg   <= wdata_next;
        byte_en_reg <= byte_en_next;
        funct3_reg  <= funct3;
        offset_reg  <= req_off;
        is_read_reg <= req_read;
      end
      if ((state_reg == BUSY) && dmem_resp && is_read_reg && !kill_reg && !flush)
        load_data_reg <= aligned_load;
    end
  end

  assign dmem_address = addr_reg;
  assign dmem_wdata   = wdata_reg;
  assign dmem_byte_en = byte_en_reg;
  assign load_data    = load_data_reg;
  assign misaligned   = misaligned_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit (32-bit instance plus a
// 64-bit instance for doubleword accesses), checked against a byte-level model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 0, req_read = 0, req_write = 0, fwd_sel = 0, flush = 0, dmem_resp = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] addr = 0, rs2_data = 0, fwd_data = 0, dmem_rdata = 0;
  logic        dmem_read, dmem_write, stall, done, misaligned;
  logic [31:0] dmem_address, dmem_wdata, load_data;
  logic [3:0]  dmem_byte_en;

  logic        w_valid = 0, w_read = 0, w_write = 0, w_fwd_sel = 0, w_flush = 0, w_resp = 0;
  logic [2:0]  w_funct3 = 0;
  logic [63:0] w_addr = 0, w_rs2 = 0, w_fwd = 0, w_rdata = 0;
  logic        w_dmem_read, w_dmem_write, w_stall, w_done, w_misaligned;
  logic [63:0] w_address, w_wdata, w_load_data;
  logic [7:0]  w_byte_en;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ld_model = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .funct3(funct3), .addr(addr), .rs2_data(rs2_data), .fwd_data(fwd_data), .fwd_sel(fwd_sel),
    .flush(flush), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_en(dmem_byte_en), .stall(stall), .done(done), .load_data(load_data),
    .misaligned(misaligned)
  );

  mem_access_unit #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .req_valid(w_valid), .req_read(w_read), .req_write(w_write),
    .funct3(w_funct3), .addr(w_addr), .rs2_data(w_rs2), .fwd_data(w_fwd), .fwd_sel(w_fwd_sel),
    .flush(w_flush), .dmem_resp(w_resp), .dmem_rdata(w_rdata), .dmem_read(w_dmem_read),
    .dmem_write(w_dmem_write), .dmem_address(w_address), .dmem_wdata(w_wdata),
    .dmem_byte_en(w_byte_en), .stall(w_stall), .done(w_done), .load_data(w_load_data),
    .misaligned(w_misaligned)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven 1ns after the edge, outputs read 2ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drives one access and checks every phase against a byte-lane model.
  task automatic txn(input bit rd, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] rs2, input logic [31:0] fwd, input bit sel,
                     input logic [31:0] rdata, input int delay);
    int          n, off;
    bit          sgn, al;
    logic [31:0] src, exp_wd, exp_ld;
    logic [3:0]  exp_be;
    longint      v;
    if (rd) n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    else    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    sgn = rd && (f3[2] == 1'b0);
    off = int'(a % 4);
    al  = (a % n) == 0;
    src = sel ? fwd : rs2;
    exp_be = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + n) exp_be[i] = 1'b1;
      exp_wd[8*i +: 8] = src[8*(i % n) +: 8];
    end
    v = longint'(rdata >> (off * 8)) & ((longint'(1) << (8 * n)) - 1);
    if (sgn && (((v >> (8 * n - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * n));
    exp_ld = v[31:0];

    req_valid = 1; req_read = rd; req_write = !rd; funct3 = f3; addr = a;
    rs2_data = rs2; fwd_data = fwd; fwd_sel = sel;
    settle();
    chk("accept_stall", stall, al);
    tick();
    req_valid = 0; req_read = 0; req_write = 0;
    settle();
    if (!al) begin
      chk("misaligned_pulse", misaligned, 1);
      chk("misaligned_no_read", dmem_read, 0);
      chk("misaligned_no_write", dmem_write, 0);
      chk("misaligned_stall", stall, 0);
      tick(); settle();
      chk("misaligned_clear", misaligned, 0);
      chk("misaligned_idle", dmem_read | dmem_write, 0);
      $display("txn %s f3=%0d addr=%08h misaligned", rd ? "load " : "store", f3, a);
      return;
    end
    for (int c = 0; c <= delay; c++) begin
      chk("busy_read", dmem_read, rd);
      chk("busy_write", dmem_write, !rd);
      chk("busy_address", dmem_address, a & 32'hFFFF_FFFC);
      chk("busy_byte_en", dmem_byte_en, exp_be);
      if (!rd) chk("busy_wdata", dmem_wdata, exp_wd);
      chk("busy_stall", stall, 1);
      chk("busy_done", done, 0);
      if (c == delay) begin
        dmem_resp = 1; dmem_rdata = rdata;
      end
      tick();
      dmem_resp = 0; dmem_rdata = $urandom;
      settle();
    end
    if (rd) ld_model = exp_ld;
    chk("done_pulse", done, 1);
    chk("done_stall", stall, 0);
    chk("done_strobes", dmem_read | dmem_write, 0);
    chk("done_load_data", load_data, ld_model);
    tick(); settle();
    chk("after_done", done, 0);
    $display("txn %s f3=%0d addr=%08h be=%h wdata=%08h load_data=%08h delay=%0d",
             rd ? "load " : "store", f3, a, exp_be, exp_wd, ld_model, delay);
  endtask

  task automatic w64_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rdata,
                          input logic [7:0] exp_be, input logic [63:0] exp_ld);
    w_valid = 1; w_read = 1; w_write = 0; w_funct3 = f3; w_addr = a;
    settle();
    chk("w64_accept_stall", w_stall, 1);
    tick();
    w_valid = 0; w_read = 0;
    settle();
    chk("w64_read", w_dmem_read, 1);
    chk("w64_byte_en", w_byte_en, exp_be);
    chk("w64_address", w_address, a & ~64'h7);
    w_resp = 1; w_rdata = rdata;
    tick();
    w_resp = 0;
    settle();
    chk("w64_done", w_done, 1);
    chk("w64_load_data", w_load_data, exp_ld);
    tick(); settle();
    $display("txn w64 load f3=%0d addr=%016h load_data=%016h", f3, a, exp_ld);
  endtask

  initial begin
    logic [31:0] a, kept;
    logic [2:0]  f3;
    bit          rd;

    // Reset state
    rst = 1;
    tick(); tick();
    rst = 0;
    settle();
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_misaligned", misaligned, 0);
    chk("rst_strobes", dmem_read | dmem_write, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_byte_en", dmem_byte_en, 0);
    chk("rst_address", dmem_address, 0);

    // sw with response three cycles after accept
    txn(0, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 32'h0, 2);
    // lb / lbu sign handling at the top lane
    txn(1, 3'b000, 32'h203, 32'h0, 32'h0, 0, 32'h80FF_FF12, 0);
    txn(1, 3'b100, 32'h203, 32'h0, 32'h0, 0, 32'h80FF_FF12, 0);
    // sh misaligned
    txn(0, 3'b001, 32'h101, 32'h1234, 32'h0, 0, 32'h0, 0);
    // sb through the forwarding path, invalid load funct3 treated as word
    txn(0, 3'b000, 32'h302, 32'h11, 32'hA5, 1, 32'h0, 1);
    txn(1, 3'b111, 32'h40, 32'h0, 32'h0, 0, 32'h8765_4321, 0);

    // flush in IDLE blocks acceptance
    req_valid = 1; req_read = 1; funct3 = 3'b010; addr = 32'h20; flush = 1;
    settle();
    chk("flush_idle_stall", stall, 0);
    tick();
    req_valid = 0; req_read = 0; flush = 0;
    settle();
    chk("flush_idle_no_read", dmem_read, 0);
    chk("flush_idle_no_fault", misaligned, 0);

    // lw killed while the bus access is in flight
    kept = ld_model;
    req_valid = 1; req_read = 1; funct3 = 3'b010; addr = 32'h10;
    tick();
    req_valid = 0; req_read = 0; flush = 1;
    settle();
    chk("kill_read_t1", dmem_read, 1);
    tick();
    flush = 0; dmem_resp = 1; dmem_rdata = 32'hCAFEF00D;
    settle();
    chk("kill_read_t2", dmem_read, 1);
    chk("kill_stall_t2", stall, 1);
    tick();
    dmem_resp = 0;
    settle();
    chk("kill_done", done, 0);
    chk("kill_load_data", load_data, kept);
    chk("kill_stall", stall, 0);
    tick(); settle();
    $display("txn load  killed addr=00000010 load_data=%08h", kept);

    // reset while BUSY, then a late response
    req_valid = 1; req_read = 1; funct3 = 3'b010; addr = 32'h80;
    tick();
    req_valid = 0; req_read = 0;
    settle();
    chk("rstbusy_read", dmem_read, 1);
    rst = 1;
    tick();
    rst = 0;
    settle();
    ld_model = 0;
    chk("rstbusy_strobes", dmem_read | dmem_write, 0);
    chk("rstbusy_stall", stall, 0);
    chk("rstbusy_load_data", load_data, 0);
    dmem_resp = 1; dmem_rdata = 32'h1357_9BDF;
    tick();
    dmem_resp = 0;
    settle();
    chk("late_resp_done", done, 0);
    chk("late_resp_load_data", load_data, 0);
    chk("late_resp_strobes", dmem_read | dmem_write, 0);
    $display("txn load  reset-in-busy addr=00000080");

    // 64-bit instance
    w64_load(3'b011, 64'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
    w64_load(3'b010, 64'h4, 64'hFEDC_BA98_7654_3210, 8'hF0, 64'hFFFF_FFFF_FEDC_BA98);
    w64_load(3'b110, 64'h4, 64'hFEDC_BA98_7654_3210, 8'hF0, 64'h0000_0000_FEDC_BA98);

    // Randomized accesses
    for (int t = 0; t < 40; t++) begin
      rd = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      txn(rd, f3, a, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
          int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
